shift_add_multiplier: RTL and testbench

Sequential 32x32 shift-add multiply-accumulate unit computing p = a*b + c in a fixed 32 iterations, one multiplier bit per clock. It is the inverse of the restoring divider in the warmup datapath. Feeding it the divider's quotient, divisor and remainder as a, b and c reconstructs the dividend, so the bench cross-checks the divider with it. It also serves as the general-purpose multiplier for the project datapath.

---
 rtl/shift_add_multiplier.sv | 121 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-add multiply-accumulate, p = a*b + c
//
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset
//   start   - request pulse, accepted in IDLE or DONE
//   a       - multiplier (N bits), captured on accept
//   b       - multiplicand (N bits), captured on accept
//   c       - addend (N bits, zero-extended), captured on accept
//   busy    - high while the N iterations are in progress
//   done    - one-cycle pulse, p is final
//   p       - accumulator (2N bits)
//   ovf     - upper half of p is non-zero
module shift_add_multiplier #(
    parameter int N = 32
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [N-1:0]   c,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p,
    output logic           ovf
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic             last_iter;

    // start is only honoured outside RUN; a pulse mid-operation is dropped.
    assign accept    = start && (state_q != RUN);
    assign last_iter = (cnt_q == CW'(N - 1));

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: load on accept, one multiplier bit per RUN cycle.
    // The multiplicand lives in a 2N-bit register so its left shifts never
    // lose bits; the final sum is bounded below 2^(2N), so acc never wraps.
    always_comb begin
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (accept) begin
            mplier_d = a;
            mcand_d  = {{N{1'b0}}, b};
            acc_d    = {{N{1'b0}}, c};
            cnt_d    = '0;
        end else if (state_q == RUN) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign p   = acc_q;
    assign ovf = |acc_q[2*N-1:N];

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] a, b, c;
    logic        busy, done, ovf;
    logic [63:0] p;

    int n_checks = 0;
    int n_fail   = 0;

    shift_add_multiplier #(.N(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .c       (c),
        .busy    (busy),
        .done    (done),
        .p       (p),
        .ovf     (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mac(input logic [31:0] ra, input logic [31:0] rb,
                                            input logic [31:0] rc);
        return 64'(ra) * 64'(rb) + 64'(rc);
    endfunction

    // One operation: pulse start, then watch 40 cycles. k counts the
    // half-cycle-sampled intervals after the accept edge (k=0 is T0..T0+1).
    // If rk >= 0, start is re-pulsed with (ra2,rb2,rc2) before edge T0+rk+1.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] tc,
                          input int rk, input logic [31:0] ra2, input logic [31:0] rb2,
                          input logic [31:0] rc2,
                          output int done_at, output int busy_n, output int done_n,
                          output logic [63:0] p_at, output logic ovf_at);
        @(negedge clock);
        a = ta; b = tb; c = tc; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        done_at = -1; busy_n = 0; done_n = 0; p_at = '0; ovf_at = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = k;
                    p_at    = p;
                    ovf_at  = ovf;
                end
            end
            if (k == rk) begin
                a = ra2; b = rb2; c = rc2; start = 1'b1;
                @(posedge clock);
                #1 start = 1'b0;
            end
        end
    endtask

    task automatic op_and_check(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                                input logic [31:0] tc, input int rk);
        int          d_at, b_n, d_n;
        logic [63:0] pa;
        logic        oa;
        logic [63:0] exp;
        exp = ref_mac(ta, tb, tc);
        run_op(ta, tb, tc, rk, 32'd3, 32'd3, 32'd0, d_at, b_n, d_n, pa, oa);
        check({tag, ".p"}, pa, exp);
        check({tag, ".ovf"}, 64'(oa), 64'(|exp[63:32]));
        check({tag, ".done_at"}, 64'(d_at), 64'd32);
        check({tag, ".busy_cycles"}, 64'(b_n), 64'd32);
        check({tag, ".done_count"}, 64'(d_n), 64'd1);
    endtask

    initial begin
        logic [31:0] dividend, divisor;
        logic [31:0] ops_a[4], ops_b[4], ops_c[4];
        logic [63:0] exp_b2b[4];
        int          idx, cyc, last;
        logic [63:0] p_final;

        reset_n = 1'b0; start = 1'b0; a = '0; b = '0; c = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst.p", p, 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.ovf", 64'(ovf), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle.busy", 64'(busy), 64'd0);
        check("idle.p", p, 64'd0);

        op_and_check("basic_7x6p5", 32'd7, 32'd6, 32'd5, -1);
        check("basic.model", ref_mac(32'd7, 32'd6, 32'd5), 64'd47);
        op_and_check("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        op_and_check("pow16", 32'h0001_0000, 32'h0001_0000, 32'd0, -1);
        op_and_check("div_100_7", 32'd14, 32'd7, 32'd2, -1);
        op_and_check("zero_a", 32'd0, 32'h1234_5678, 32'd9, -1);

        // start re-pulsed before edge T0+10 must be ignored
        op_and_check("repulse", 32'd9, 32'd9, 32'd1, 9);

        // Async reset mid-operation
        @(negedge clock);
        a = 32'hFFFF_FFFF; b = 32'h1234_5678; c = 32'd7; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (15) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("arst.p", p, 64'd0);
        check("arst.busy", 64'(busy), 64'd0);
        check("arst.done", 64'(done), 64'd0);
        check("arst.ovf", 64'(ovf), 64'd0);
        #1 reset_n = 1'b1;
        op_and_check("after_rst", 32'd2, 32'd3, 32'd4, -1);

        // Back-to-back with start held high
        for (int i = 0; i < 4; i++) begin
            ops_a[i] = $urandom; ops_b[i] = $urandom; ops_c[i] = $urandom;
            exp_b2b[i] = ref_mac(ops_a[i], ops_b[i], ops_c[i]);
        end
        @(negedge clock);
        a = ops_a[0]; b = ops_b[0]; c = ops_c[0]; start = 1'b1;
        @(posedge clock);
        idx = 0; cyc = 0; last = 0;
        while (idx < 4 && cyc < 4 * 33 + 20) begin
            @(negedge clock);
            cyc++;
            if (done) begin
                check($sformatf("b2b%0d.p", idx), p, exp_b2b[idx]);
                check($sformatf("b2b%0d.spacing", idx), 64'(cyc - last), 64'd33);
                last = cyc;
                idx++;
                if (idx == 4) begin
                    start = 1'b0;
                end else begin
                    a = ops_a[idx]; b = ops_b[idx]; c = ops_c[idx];
                end
            end
        end
        start = 1'b0;
        check("b2b.results", 64'(idx), 64'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            p_final = p;
            check("b2b.hold_p", p_final, exp_b2b[3]);
            check("b2b.hold_busy", 64'(busy), 64'd0);
        end

        // Divider round-trip with random operands
        for (int i = 0; i < 1000; i++) begin
            dividend = $urandom;
            case (i % 3)
                0:       divisor = $urandom_range(1, 255);
                1:       divisor = $urandom_range(1, 32'hFFFF);
                default: divisor = ($urandom | 32'd1);
            endcase
            op_and_check($sformatf("rt%0d", i), dividend / divisor, divisor, dividend % divisor, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
